// File: rtl/tcm_boot_ctrl.sv
// -----------------------------------------------------------------------------
// tcm_boot_ctrl
//
// Boot and run sequencer for the RISC-V TCM SoC.
//   1. LOAD   : streams a program image from the loader into the TCM
//               instruction write port, one word per beat, core held in reset.
//   2. SETTLE : lets the final TCM write land, core still in reset.
//   3. RUN    : releases core reset and watches fetch for END_INST, bounded
//               by a run-cycle budget.
//   4. DRAIN  : keeps the core running a few cycles after END_INST is seen.
//   5. DONE / ERR : core back in reset, result reported, counters hold.
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous active-low reset
//   start_i         start pulse, honoured in IDLE, DONE and ERR only
//   ld_valid_i      loader word valid
//   ld_data_i       loader instruction word
//   ld_last_i       final word of the image (qualified by ld_valid_i)
//   ld_ready_o      loader ready (high throughout LOAD)
//   tb_inst_we_o    TCM instruction byte-write enables
//   tb_inst_addr_o  TCM instruction write byte address
//   tb_inst_data_o  TCM instruction write data
//   rst_cpu_o       core reset, active-high (low only in RUN and DRAIN)
//   fetch_valid_i   fetch-stage instruction valid
//   fetch_inst_i    fetch-stage instruction
//   busy_o          high in LOAD, SETTLE, RUN and DRAIN
//   done_o          program completed (sticky until next start)
//   timeout_o       run budget exhausted (sticky until next start)
//   word_cnt_o      number of words loaded
//   cycle_cnt_o     number of cycles spent in RUN
// -----------------------------------------------------------------------------
module tcm_boot_ctrl #(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned MAX_WORDS      = 100,
  parameter int unsigned SETTLE_CYCLES  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 40000,
  parameter int unsigned DRAIN_CYCLES   = 5,
  parameter logic [31:0] END_INST       = 32'h00008067
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        ld_valid_i,
  input  logic [31:0] ld_data_i,
  input  logic        ld_last_i,
  output logic        ld_ready_o,
  output logic [3:0]  tb_inst_we_o,
  output logic [31:0] tb_inst_addr_o,
  output logic [31:0] tb_inst_data_o,
  output logic        rst_cpu_o,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_inst_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] word_cnt_o,
  output logic [31:0] cycle_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] LAST_IDX    = 32'(MAX_WORDS - 1);
  localparam logic [31:0] SETTLE_LEN  = 32'(SETTLE_CYCLES);
  localparam logic [31:0] DRAIN_LEN   = 32'(DRAIN_CYCLES);
  localparam logic [31:0] TIMEOUT_LEN = 32'(TIMEOUT_CYCLES);

  state_t      state;
  logic [31:0] addr_next;   // byte address for the next accepted beat
  logic [31:0] phase_cnt;   // cycles already spent in SETTLE or DRAIN

  logic accept;
  logic last_beat;
  logic end_hit;
  logic idle_like;

  always_comb begin
    idle_like  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    ld_ready_o = (state == S_LOAD);
    busy_o     = !idle_like;
    rst_cpu_o  = !((state == S_RUN) || (state == S_DRAIN));
    accept     = ld_valid_i && (state == S_LOAD);
    // word_cnt_o still holds the index of the beat being accepted here
    last_beat  = ld_last_i || (word_cnt_o == LAST_IDX);
    end_hit    = fetch_valid_i && (fetch_inst_i == END_INST);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= S_IDLE;
      tb_inst_we_o   <= '0;
      tb_inst_addr_o <= BASE_ADDR;
      tb_inst_data_o <= '0;
      addr_next      <= BASE_ADDR;
      phase_cnt      <= '0;
      done_o         <= 1'b0;
      timeout_o      <= 1'b0;
      word_cnt_o     <= '0;
      cycle_cnt_o    <= '0;
    end else begin
      // TCM write port: one registered write per accepted beat
      tb_inst_we_o <= '0;
      if (accept) begin
        tb_inst_we_o   <= '1;
        tb_inst_addr_o <= addr_next;
        tb_inst_data_o <= ld_data_i;
        addr_next      <= addr_next + 32'd4;
        word_cnt_o     <= word_cnt_o + 32'd1;
      end

      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state       <= S_LOAD;
            addr_next   <= BASE_ADDR;
            word_cnt_o  <= '0;
            cycle_cnt_o <= '0;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
          end
        end

        S_LOAD: begin
          if (accept && last_beat) begin
            state     <= S_SETTLE;
            phase_cnt <= '0;
          end
        end

        S_SETTLE: begin
          if (phase_cnt + 32'd1 >= SETTLE_LEN) begin
            state       <= S_RUN;
            cycle_cnt_o <= 32'd1;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end

        S_RUN: begin
          // END_INST takes priority over an expiring budget in the same cycle
          if (end_hit) begin
            state     <= S_DRAIN;
            phase_cnt <= '0;
          end else if (cycle_cnt_o >= TIMEOUT_LEN) begin
            state     <= S_ERR;
            timeout_o <= 1'b1;
          end else begin
            cycle_cnt_o <= cycle_cnt_o + 32'd1;
          end
        end

        S_DRAIN: begin
          if (phase_cnt + 32'd1 >= DRAIN_LEN) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
